scan_config_loader: RTL and testbench

- Serialises configuration bitstream words onto the fabric scan chain. The chain is the concatenated shift_reg instances of connection blocks, switch blocks and CLBs.
- Drives the chain head (scan_in/scan_en of the first block) and observes the chain tail. The displaced old configuration is packed into readback words.
- Sits directly upstream of the connection-block scan chain, between the off-chip bitstream interface and the fabric.

---
 rtl/fabric_cfg_pkg.sv | 20 ++
 rtl/scan_word_packer.sv | 60 ++++++
 rtl/scan_config_loader.sv | 170 +++++++++++++++++
 tb/tb_scan_config_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
// Shared types and constants for the fabric configuration scan loader.
package fabric_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_e;

    // Scan bits in one tile's chain and the default bitstream word width
    localparam int unsigned TILE_CHAIN_LENGTH = 64;
    localparam int unsigned TILE_WORD_WIDTH   = 8;

    // Bitstream words needed to cover a chain, last word possibly partial
    function automatic int unsigned num_words(input int unsigned chain_len,
                                              input int unsigned word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/scan_word_packer.sv
// LSB-first deserialiser that packs chain tail bits into readback words.
module scan_word_packer #(
    parameter int unsigned WORD_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  en_i,
    input  logic                  bit_i,
    input  logic                  flush_i,
    output logic [WORD_WIDTH-1:0] rb_data_o,
    output logic                  rb_valid_o
);

    localparam int unsigned IDX_W = $clog2(WORD_WIDTH + 1);

    logic [WORD_WIDTH-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WORD_WIDTH-1:0] rb_data_q, rb_data_d;
    logic                  rb_valid_q, rb_valid_d;

    // A full word or a flush emits the accumulator; unfilled bits stay zero
    always_comb begin
        acc_d      = acc_q;
        idx_d      = idx_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        if (en_i) begin
            for (int i = 0; i < int'(WORD_WIDTH); i++) begin
                if (idx_q == IDX_W'(i)) begin
                    acc_d[i] = bit_i;
                end
            end
            idx_d = idx_q + IDX_W'(1);
        end
        if ((en_i && (idx_q == IDX_W'(WORD_WIDTH - 1))) || flush_i) begin
            rb_data_d  = acc_d;
            rb_valid_d = 1'b1;
            acc_d      = '0;
            idx_d      = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q      <= '0;
            idx_q      <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign rb_data_o  = rb_data_q;
    assign rb_valid_o = rb_valid_q;

endmodule

// File: rtl/scan_config_loader.sv
// Serialises bitstream words onto the fabric scan chain and packs the
// displaced chain contents into readback words.
module scan_config_loader
    import fabric_cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LENGTH = TILE_CHAIN_LENGTH,
    parameter int unsigned WORD_WIDTH   = TILE_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  scan_out,
    output logic                  scan_en,
    input  logic                  chain_tail,
    output logic [WORD_WIDTH-1:0] rb_data,
    output logic                  rb_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned NUM_WORDS = num_words(CHAIN_LENGTH, WORD_WIDTH);
    localparam int unsigned BL_W      = $clog2(CHAIN_LENGTH + 1);
    localparam int unsigned WL_W      = $clog2(NUM_WORDS + 1);
    localparam int unsigned IDX_W     = $clog2(WORD_WIDTH + 1);

    load_state_e           state_q, state_d;
    logic [WORD_WIDTH-1:0] buf_q, buf_d;
    logic                  buf_full_q, buf_full_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [BL_W-1:0]       bits_left_q, bits_left_d;
    logic [WL_W-1:0]       words_left_q, words_left_d;
    logic                  scan_out_q, scan_out_d;
    logic                  scan_en_q, scan_en_d;
    logic                  last_shift_q, last_shift_d;
    logic                  final_rb_q, final_rb_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  buf_bit_c;
    logic                  shift_c;
    logic                  buf_drain_c;
    logic                  in_ready_c;
    logic                  flush_c;

    always_comb begin
        buf_bit_c = 1'b0;
        for (int i = 0; i < int'(WORD_WIDTH); i++) begin
            if (bit_idx_q == IDX_W'(i)) begin
                buf_bit_c = buf_q[i];
            end
        end
    end

    // Next state, buffer handoff and shift issue
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        bit_idx_d    = bit_idx_q;
        bits_left_d  = bits_left_q;
        words_left_d = words_left_q;
        scan_out_d   = scan_out_q;
        scan_en_d    = 1'b0;
        last_shift_d = 1'b0;
        final_rb_d   = 1'b0;
        shift_c      = 1'b0;
        buf_drain_c  = 1'b0;
        in_ready_c   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = LOAD;
                    bits_left_d  = BL_W'(CHAIN_LENGTH);
                    words_left_d = WL_W'(NUM_WORDS);
                    buf_full_d   = 1'b0;
                    bit_idx_d    = '0;
                end
            end
            LOAD: begin
                shift_c = buf_full_q && (bits_left_q != '0);
                if (shift_c) begin
                    scan_out_d   = buf_bit_c;
                    scan_en_d    = 1'b1;
                    bits_left_d  = bits_left_q - BL_W'(1);
                    bit_idx_d    = bit_idx_q + IDX_W'(1);
                    last_shift_d = (bits_left_q == BL_W'(1));
                    // Word exhausted, or chain full mid-word: drop the rest
                    if ((bit_idx_q == IDX_W'(WORD_WIDTH - 1)) || (bits_left_q == BL_W'(1))) begin
                        buf_drain_c = 1'b1;
                        buf_full_d  = 1'b0;
                        bit_idx_d   = '0;
                    end
                end
                in_ready_c = (words_left_q != '0) && (!buf_full_q || buf_drain_c);
                if (in_ready_c && in_valid) begin
                    buf_d        = in_data;
                    buf_full_d   = 1'b1;
                    bit_idx_d    = '0;
                    words_left_d = words_left_q - WL_W'(1);
                end
                final_rb_d = scan_en_q && last_shift_q;
                if (final_rb_q) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == LOAD);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            bit_idx_q    <= '0;
            bits_left_q  <= '0;
            words_left_q <= '0;
            scan_out_q   <= 1'b0;
            scan_en_q    <= 1'b0;
            last_shift_q <= 1'b0;
            final_rb_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            bit_idx_q    <= bit_idx_d;
            bits_left_q  <= bits_left_d;
            words_left_q <= words_left_d;
            scan_out_q   <= scan_out_d;
            scan_en_q    <= scan_en_d;
            last_shift_q <= last_shift_d;
            final_rb_q   <= final_rb_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // The final shift's tail bit closes the last, possibly partial, word
    assign flush_c = scan_en_q && last_shift_q;

    scan_word_packer #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_packer (
        .clk_i     (clk),
        .reset_i   (reset),
        .en_i      (scan_en_q),
        .bit_i     (chain_tail),
        .flush_i   (flush_c),
        .rb_data_o (rb_data),
        .rb_valid_o(rb_valid)
    );

    assign in_ready = in_ready_c;
    assign scan_out = scan_out_q;
    assign scan_en  = scan_en_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_scan_config_loader.sv
// Directed bench: three loader configurations, each driving a modelled chain.
module tb_scan_config_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance a: CHAIN_LENGTH=8, WORD_WIDTH=4
    logic       start_a, in_valid_a, in_ready_a, scan_out_a, scan_en_a, tail_a;
    logic       rb_valid_a, busy_a, done_a, pre_a;
    logic [3:0] in_data_a, rb_data_a;
    logic [7:0] chain_a = '0, pre_val_a;
    // Instance b: CHAIN_LENGTH=10, WORD_WIDTH=4
    logic       start_b, in_valid_b, in_ready_b, scan_out_b, scan_en_b, tail_b;
    logic       rb_valid_b, busy_b, done_b, pre_b;
    logic [3:0] in_data_b, rb_data_b;
    logic [9:0] chain_b = '0, pre_val_b;
    // Instance c: CHAIN_LENGTH=1, WORD_WIDTH=1
    logic       start_c, in_valid_c, in_ready_c, scan_out_c, scan_en_c, tail_c;
    logic       rb_valid_c, busy_c, done_c, pre_c;
    logic [0:0] in_data_c, rb_data_c;
    logic [0:0] chain_c = '0, pre_val_c;

    scan_config_loader #(.CHAIN_LENGTH(8), .WORD_WIDTH(4)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .in_data(in_data_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .scan_out(scan_out_a),
        .scan_en(scan_en_a), .chain_tail(tail_a), .rb_data(rb_data_a),
        .rb_valid(rb_valid_a), .busy(busy_a), .done(done_a));

    scan_config_loader #(.CHAIN_LENGTH(10), .WORD_WIDTH(4)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .in_data(in_data_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .scan_out(scan_out_b),
        .scan_en(scan_en_b), .chain_tail(tail_b), .rb_data(rb_data_b),
        .rb_valid(rb_valid_b), .busy(busy_b), .done(done_b));

    scan_config_loader #(.CHAIN_LENGTH(1), .WORD_WIDTH(1)) u_c (
        .clk(clk), .reset(reset), .start(start_c), .in_data(in_data_c),
        .in_valid(in_valid_c), .in_ready(in_ready_c), .scan_out(scan_out_c),
        .scan_en(scan_en_c), .chain_tail(tail_c), .rb_data(rb_data_c),
        .rb_valid(rb_valid_c), .busy(busy_c), .done(done_c));

    // Chain models: scan_in enters at the top bit, tail is bit 0
    assign tail_a = chain_a[0];
    assign tail_b = chain_b[0];
    assign tail_c = chain_c[0];

    always @(posedge clk) begin
        if (pre_a) chain_a <= pre_val_a;
        else if (scan_en_a) chain_a <= {scan_out_a, chain_a[7:1]};
        if (pre_b) chain_b <= pre_val_b;
        else if (scan_en_b) chain_b <= {scan_out_b, chain_b[9:1]};
        if (pre_c) chain_c <= pre_val_c;
        else if (scan_en_c) chain_c <= scan_out_c;
    end

    int         en_a[$], en_b[$], en_c[$];
    logic       so_a[$], so_b[$], so_c[$];
    logic [3:0] rb_a[$], rb_b[$], rb_c[$];

    always @(negedge clk) begin
        if (scan_en_a) begin en_a.push_back(cyc); so_a.push_back(scan_out_a); end
        if (scan_en_b) begin en_b.push_back(cyc); so_b.push_back(scan_out_b); end
        if (scan_en_c) begin en_c.push_back(cyc); so_c.push_back(scan_out_c); end
        if (rb_valid_a) rb_a.push_back(rb_data_a);
        if (rb_valid_b) rb_b.push_back(rb_data_b);
        if (rb_valid_c) rb_c.push_back(4'(rb_data_c));
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_ready(input int inst);
        case (inst) 0: return in_ready_a; 1: return in_ready_b; default: return in_ready_c; endcase
    endfunction
    function automatic logic get_done(input int inst);
        case (inst) 0: return done_a; 1: return done_b; default: return done_c; endcase
    endfunction
    function automatic logic get_busy(input int inst);
        case (inst) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
    endfunction
    function automatic int en_size(input int inst);
        case (inst) 0: return en_a.size(); 1: return en_b.size(); default: return en_c.size(); endcase
    endfunction
    function automatic int rb_size(input int inst);
        case (inst) 0: return rb_a.size(); 1: return rb_b.size(); default: return rb_c.size(); endcase
    endfunction

    task automatic set_in(input int inst, input logic v, input logic [3:0] d);
        case (inst)
            0: begin in_valid_a = v; in_data_a = d; end
            1: begin in_valid_b = v; in_data_b = d; end
            default: begin in_valid_c = v; in_data_c = d[0]; end
        endcase
    endtask

    task automatic set_start(input int inst, input logic v);
        case (inst) 0: start_a = v; 1: start_b = v; default: start_c = v; endcase
    endtask

    task automatic preload(input int inst, input logic [31:0] val);
        case (inst)
            0: begin pre_val_a = val[7:0]; pre_a = 1'b1; end
            1: begin pre_val_b = val[9:0]; pre_b = 1'b1; end
            default: begin pre_val_c = val[0]; pre_c = 1'b1; end
        endcase
        @(posedge clk); #1;
        pre_a = 1'b0; pre_b = 1'b0; pre_c = 1'b0;
    endtask

    task automatic do_start(input int inst);
        set_start(inst, 1'b1);
        @(posedge clk); #1;
        set_start(inst, 1'b0);
    endtask

    // Offers n words; gap_at inserts 5 idle-ready cycles (with a stray start) before that word
    task automatic feed(input int inst, input logic [3:0] w [3], input int n,
                        input int gap_at, output int acc0);
        int i = 0;
        int budget = 0;
        int gap = gap_at;
        acc0 = -1;
        while (i < n && budget < 200) begin
            if (i == gap) begin
                set_in(inst, 1'b0, 4'h0);
                do begin @(negedge clk); budget++; end while (!get_ready(inst) && budget < 200);
                @(posedge clk); #1;
                set_start(inst, 1'b1);
                @(posedge clk); #1;
                set_start(inst, 1'b0);
                repeat (3) @(posedge clk);
                #1;
                gap = -1;
            end
            set_in(inst, 1'b1, w[i]);
            @(negedge clk); budget++;
            if (get_ready(inst)) begin
                if (i == 0) acc0 = cyc;
                i++;
            end
            @(posedge clk); #1;
        end
        set_in(inst, 1'b0, 4'h0);
        check("feed_accepted", 32'(i), 32'(n));
    endtask

    task automatic wait_done(input int inst, input string tag);
        int b = 0;
        do begin @(negedge clk); b++; end while (!get_done(inst) && b < 100);
        check({tag, "_done"}, 32'(get_done(inst)), 32'd1);
        check({tag, "_busy"}, 32'(get_busy(inst)), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic analyze(input string tag, input int inst, input int eb, input int rbb,
                           input int acc0, input int exp_n, input logic [31:0] exp_so,
                           input int exp_gap, input int exp_rb_n, input logic [3:0] exp_rb [3],
                           input logic [31:0] exp_chain);
        int ec[$];
        logic sb[$];
        logic [3:0] rw[$];
        logic [31:0] ch, so;
        int n, gsum, gnum, d;
        case (inst)
            0: begin ec = en_a; sb = so_a; rw = rb_a; ch = 32'(chain_a); end
            1: begin ec = en_b; sb = so_b; rw = rb_b; ch = 32'(chain_b); end
            default: begin ec = en_c; sb = so_c; rw = rb_c; ch = 32'(chain_c); end
        endcase
        n = ec.size() - eb;
        check({tag, "_shifts"}, 32'(n), 32'(exp_n));
        so = '0;
        for (int k = 0; k < n && k < 32; k++) so = so | (32'(sb[eb + k]) << k);
        check({tag, "_scan_out"}, so, exp_so);
        if (n > 0) check({tag, "_first_en_lat"}, 32'(ec[eb] - acc0), 32'd2);
        gsum = 0; gnum = 0;
        for (int k = eb + 1; k < ec.size(); k++) begin
            d = ec[k] - ec[k - 1] - 1;
            gsum += d;
            if (d != 0) gnum++;
        end
        check({tag, "_stall_cycles"}, 32'(gsum), 32'(exp_gap));
        check({tag, "_stall_runs"}, 32'(gnum), (exp_gap != 0) ? 32'd1 : 32'd0);
        check({tag, "_rb_count"}, 32'(rw.size() - rbb), 32'(exp_rb_n));
        for (int k = 0; k < exp_rb_n; k++) begin
            if (rbb + k < rw.size()) check({tag, "_rb_word"}, 32'(rw[rbb + k]), 32'(exp_rb[k]));
        end
        check({tag, "_chain"}, ch, exp_chain);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc0, eb, rbb, budget;
        reset = 1'b1;
        pre_a = 1'b0; pre_b = 1'b0; pre_c = 1'b0;
        pre_val_a = '0; pre_val_b = '0; pre_val_c = '0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        set_in(0, 1'b0, 4'h0); set_in(1, 1'b0, 4'h0); set_in(2, 1'b0, 4'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ctrl_a", 32'({in_ready_a, scan_out_a, scan_en_a, rb_valid_a, busy_a, done_a}), 32'd0);
        check("rst_rb_data_a", 32'(rb_data_a), 32'd0);
        check("rst_ctrl_c", 32'({in_ready_c, scan_out_c, scan_en_c, rb_valid_c, busy_c, done_c}), 32'd0);
        @(posedge clk); #1;

        // Basic load 0x3, 0xC over chain 0xA5
        preload(0, 32'hA5);
        eb = en_size(0); rbb = rb_size(0);
        do_start(0);
        feed(0, '{4'h3, 4'hC, 4'h0}, 2, -1, acc0);
        wait_done(0, "t1");
        analyze("t1", 0, eb, rbb, acc0, 8, 32'hC3, 0, 2, '{4'h5, 4'hA, 4'h0}, 32'hC3);

        // Restart from DONE with a 5-cycle valid gap and a stray start mid-load
        eb = en_size(0); rbb = rb_size(0);
        do_start(0);
        @(negedge clk);
        check("t2_busy_after_start", 32'(busy_a), 32'd1);
        check("t2_done_dropped", 32'(done_a), 32'd0);
        @(posedge clk); #1;
        feed(0, '{4'h6, 4'h9, 4'h0}, 2, 1, acc0);
        wait_done(0, "t2");
        analyze("t2", 0, eb, rbb, acc0, 8, 32'h96, 5, 2, '{4'h3, 4'hC, 4'h0}, 32'h96);

        // Partial final word on a 10-bit chain
        preload(1, 32'h1B6);
        eb = en_size(1); rbb = rb_size(1);
        do_start(1);
        feed(1, '{4'hF, 4'h0, 4'hE}, 3, -1, acc0);
        set_in(1, 1'b1, 4'h7);
        @(negedge clk);
        check("t3_extra_word_ready", 32'(in_ready_b), 32'd0);
        @(posedge clk); #1;
        set_in(1, 1'b0, 4'h0);
        wait_done(1, "t3");
        analyze("t3", 1, eb, rbb, acc0, 10, 32'h20F, 0, 3, '{4'h6, 4'hB, 4'h1}, 32'h20F);

        // Reset after three shifts, then a clean reload
        preload(0, 32'h00);
        eb = en_size(0);
        do_start(0);
        feed(0, '{4'h5, 4'h0, 4'h0}, 1, -1, acc0);
        budget = 0;
        while (en_size(0) - eb < 3 && budget < 50) begin @(negedge clk); budget++; end
        check("t4_three_shifts_seen", 32'(en_size(0) - eb), 32'd3);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("t4_rst_scan_en", 32'(scan_en_a), 32'd0);
        check("t4_rst_busy_done", 32'({busy_a, done_a}), 32'd0);
        check("t4_rst_in_ready", 32'(in_ready_a), 32'd0);
        @(posedge clk); #1;
        preload(0, 32'h3C);
        eb = en_size(0); rbb = rb_size(0);
        do_start(0);
        feed(0, '{4'h5, 4'hA, 4'h0}, 2, -1, acc0);
        wait_done(0, "t4");
        analyze("t4", 0, eb, rbb, acc0, 8, 32'hA5, 0, 2, '{4'hC, 4'h3, 4'h0}, 32'hA5);

        // Single-bit chain with single-bit words
        preload(2, 32'h1);
        eb = en_size(2); rbb = rb_size(2);
        do_start(2);
        feed(2, '{4'h1, 4'h0, 4'h0}, 1, -1, acc0);
        wait_done(2, "t5");
        analyze("t5", 2, eb, rbb, acc0, 1, 32'h1, 0, 1, '{4'h1, 4'h0, 4'h0}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
